// File: rtl/j_serial_accum.sv
// Eight-lane bit-serial accumulator: deskews staggered LSB-first lane streams, sums the
// eight two's-complement words bit-serially and holds the result in a valid/ready register.
module j_serial_accum #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = DATA_W + 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              serial_in,
  input  logic [7:0]              serial_en,
  output logic signed [ACC_W-1:0] sum,
  output logic                    sum_valid,
  input  logic                    sum_ready,
  output logic                    frame_err,
  output logic                    overrun,
  input  logic                    err_clr,
  output logic                    busy
);

  localparam int unsigned KW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [KW-1:0] KMax = KW'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StFlush} state_e;

  logic [7:0] a_d, a_en, dly_busy;

  // Lane i is delayed 7-i cycles so all lanes line up with lane 7.
  for (genvar i = 0; i < 8; i++) begin : g_lane
    localparam int unsigned Depth = 7 - i;
    if (Depth == 0) begin : g_pass
      assign a_d[i]      = serial_in[i];
      assign a_en[i]     = serial_en[i];
      assign dly_busy[i] = 1'b0;
    end else begin : g_dly
      logic [Depth-1:0] d_q, e_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          d_q <= '0;
          e_q <= '0;
        end else begin
          d_q[0] <= serial_in[i];
          e_q[0] <= serial_en[i];
          for (int unsigned s = 1; s < Depth; s++) begin
            d_q[s] <= d_q[s-1];
            e_q[s] <= e_q[s-1];
          end
        end
      end
      assign a_d[i]      = d_q[Depth-1];
      assign a_en[i]     = e_q[Depth-1];
      assign dly_busy[i] = |e_q;
    end
  end

  logic [7:0]       ad_q, aen_q;
  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  logic [3:0]       pc;
  logic [ACC_W-1:0] pc_ext, weight, result;
  logic             done, ferr_set, load;

  always_comb begin
    pc = '0;
    for (int i = 0; i < 8; i++) begin
      pc = pc + 4'(ad_q[i]);
    end
  end

  assign pc_ext = {{(ACC_W-4){1'b0}}, pc};
  assign weight = pc_ext << k_q;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    acc_d    = acc_q;
    done     = 1'b0;
    result   = '0;
    ferr_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (aen_q == 8'hFF) begin
          if (DATA_W == 1) begin
            // Single-bit words: the only bit is the sign bit.
            done   = 1'b1;
            result = '0 - pc_ext;
          end else begin
            acc_d   = pc_ext;
            k_d     = KW'(1);
            state_d = StAccum;
          end
        end else if (aen_q != 8'h00) begin
          ferr_set = 1'b1;
          state_d  = StFlush;
        end
      end
      StAccum: begin
        if (aen_q == 8'hFF) begin
          if (k_q == KMax) begin
            done    = 1'b1;
            result  = acc_q - weight;
            state_d = StIdle;
          end else begin
            acc_d = acc_q + weight;
            k_d   = k_q + KW'(1);
          end
        end else begin
          ferr_set = 1'b1;
          acc_d    = '0;
          state_d  = (aen_q == 8'h00) ? StIdle : StFlush;
        end
      end
      StFlush: begin
        if (aen_q == 8'h00) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    load    = done & (~valid_q | sum_ready);
    sum_d   = load ? result : sum_q;
    valid_d = load ? 1'b1 : (valid_q & ~sum_ready);
    // A set event in the same cycle overrides the clear.
    ferr_d  = ferr_set | (ferr_q & ~err_clr);
    ovr_d   = (done & ~load) | (ovr_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ad_q    <= '0;
      aen_q   <= '0;
      state_q <= StIdle;
      k_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ad_q    <= a_d;
      aen_q   <= a_en;
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sum       = sum_q;
  assign sum_valid = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q == StAccum) | (|dly_busy) | (|aen_q);

endmodule
